// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one synchronous ROM read port (1-cycle registered read) between
//   NUM_REQ requesters. Arbitration is round-robin by default; defining
//   ROM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) and
//   removes the round-robin pointer. One accept per clock, responses return
//   two cycles after accept, in accept order, tagged by a one-hot rsp_valid.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot grant (zero when nothing is valid or in reset)
//   rsp_valid  one-hot response tag, presented for exactly one cycle
//   rsp_data   shared read data (passthrough of rom_data)
//   rom_addr   registered ROM address
//   rom_data   ROM registered output
//   busy       a read is in flight in either pipeline stage
module rom_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      busy
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          NREQ = int'(NUM_REQ);

    logic            grant_any;
    logic [ID_W-1:0] grant_id;

    logic            s1_valid_q;
    logic [ID_W-1:0] s1_id_q;
    logic            s2_valid_q;
    logic [ID_W-1:0] s2_id_q;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest valid index is the last one written.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        if (!rst_n) begin
            grant_any = 1'b0;
        end
    end
`else
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] cand_id;
    int              cand;

    // Scan offsets far to near so the requester closest after last_grant wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = 0;
        cand_id   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_id = ID_W'(cand);
            if (req_valid[cand_id]) begin
                grant_any = 1'b1;
                grant_id  = cand_id;
            end
        end
        if (!rst_n) begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            last_grant_q <= grant_id;
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Stage 1 tracks the address being presented to the ROM; stage 2 lines up
    // with the ROM's registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s1_valid_q <= grant_any;
            if (grant_any) begin
                s1_id_q  <= grant_id;
                rom_addr <= req_addr[grant_id*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (s2_valid_q) begin
            rsp_valid[s2_id_q] = 1'b1;
        end
    end

    assign rsp_data = rom_data;
    assign busy     = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
//   Randomised and directed stimulus against a queue-based reference model.
//   The driver predicts grants and pushes expected responses; a monitor pops
//   and compares every cycle. Ports: none.
module tb_rom_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        busy;

    rom_read_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         ptr      = 3;
    logic [7:0] rom[256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Winner is the first valid requester in search order, per the arbitration rule.
    function automatic int pick(input logic [3:0] v);
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
        return -1;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] a);
        int         id;
        logic [3:0] e;
        exp_t       t;
        @(negedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        #1;
        e = 4'b0000;
        if (rst_n) begin
            id = pick(v);
            if (id >= 0) begin
                e      = 4'(1 << id);
                t.id   = id;
                t.data = rom[a[id*8 +: 8]];
                t.due  = cyc + 2;
                q.push_back(t);
                ptr = id;
            end
        end else begin
            check("rom_addr_in_reset", 32'(rom_addr), 32'd0);
        end
        check("req_ready", 32'(req_ready), 32'(e));
    endtask

    task automatic reset_for(input int n);
        @(negedge clk);
        #1;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        q.delete();
        ptr = 3;
        repeat (n) drive(4'($urandom_range(0, 15)), $urandom());
        @(negedge clk);
        #1;
        req_valid = 4'b0000;
        rst_n     = 1'b1;
    endtask

    // Monitor: samples registered outputs on the falling edge.
    initial begin
        logic [3:0] e;
        logic       busy_exp;
        forever begin
            @(negedge clk);
            busy_exp = 1'b0;
            foreach (q[i]) begin
                if (q[i].due == cyc || q[i].due == cyc + 1) busy_exp = 1'b1;
            end
            check("busy", 32'(busy), 32'(busy_exp));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = 4'(1 << q[0].id);
                check("rsp_valid", 32'(rsp_valid), 32'(e));
                check("rsp_data", 32'(rsp_data), 32'(q[0].data));
                void'(q.pop_front());
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hFF;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_addr  = 32'h0;
        #1;
        rst_n = 1'b0;
        // Reset with random requests: no grants, outputs cleared.
        repeat (3) drive(4'($urandom_range(0, 15)), $urandom());
        @(negedge clk);
        #1;
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        drive(4'b1111, 32'h33221100);
        drive(4'b0000, 32'h0);

        // Single read by requester 1.
        drive(4'b0010, 32'h00001000);
        repeat (4) drive(4'b0000, 32'h0);

        // Full contention from a fresh pointer, ending with last grant 3.
        reset_for(1);
        repeat (12) drive(4'b1111, 32'h33221100);
        // Pointer wrap.
        repeat (3) drive(4'b0101, 32'h44332211);
        repeat (3) drive(4'b0000, 32'h0);

        // Reset mid-flight: accepted request must never respond.
        drive(4'b0100, 32'h00550000);
        reset_for(2);
        repeat (4) drive(4'b0000, 32'h0);

        // Requesters 0 and 3 contending, then 0 drops.
        repeat (8) drive(4'b1001, 32'h77000066);
        repeat (2) drive(4'b1000, 32'h78000000);
        repeat (3) drive(4'b0000, 32'h0);

        // Random traffic.
        repeat (300) drive(4'($urandom_range(0, 15)), $urandom());
        repeat (4) drive(4'b0000, 32'h0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
